myproject_acc_requant_28s_16s: RTL and testbench
================================================

Name: myproject_acc_requant_28s_16s

Overview:
Downstream consumer of the 16s x 14ns -> 28-bit product stage in the pruned CNN datapath. Sums a variable-length stream of signed 28-bit products into one dot-product, adds a per-neuron bias, then rounds, right-shifts and saturates the sum to the 16-bit layer output format. Uses valid/ready handshakes on both sides and produces one result per vector.

Parameters:
PROD_WIDTH, 28, width of signed product input
ACC_WIDTH, 36, width of internal signed accumulator
BIAS_WIDTH, 16, width of signed bias, in the same scale as the output
OUT_WIDTH, 16, width of signed result
FRAC_SHIFT, 12, right-shift from product scale to output scale; must be >= 1

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst  in  1  synchronous, active-high reset
prod_din  in  PROD_WIDTH  signed product beat
prod_valid  in  1  beat valid
prod_last  in  1  final beat of vector, qualified by prod_valid
prod_ready  out  1  block can accept a beat
bias_din  in  BIAS_WIDTH  signed bias; sampled only on the first beat of a vector
res_dout  out  OUT_WIDTH  signed requantised result
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_ovf  out  1  saturation occurred; qualified by res_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, acc=0, res_dout=0, res_valid=0, res_ovf=0, busy=0.
- Beat accepted = prod_valid & prod_ready.
- prod_ready = 1 in IDLE and ACC; 0 in RQ and OUT.
- FSM states: IDLE, ACC, RQ, OUT.
- IDLE, on accept:
  - acc <= sext(bias_din) << FRAC_SHIFT, plus sext(prod_din).
  - Next state is RQ if prod_last, otherwise ACC.
- ACC, on accept:
  - acc <= acc + sext(prod_din).
  - Next state is RQ if prod_last, otherwise ACC.
  - No accept: hold.
- RQ (exactly 1 cycle):
  - r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT: arithmetic shift, round-half-up.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register res_dout; res_ovf=1 iff clamped; res_valid<=1; go to OUT.
- OUT:
  - res_dout, res_ovf and res_valid are held stable while res_ready=0.
  - On res_valid & res_ready: res_valid<=0, acc<=0, go to IDLE.
  - The next vector's first beat can be accepted the cycle after the handshake.
- Latency: last beat accepted at cycle N -> res_valid high at cycle N+2.
- Throughput: one vector per (beats + 2 + stall) cycles. No bubble-free overlap of vectors.
- Arithmetic:
  - All operands are sign-extended to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH; no internal overflow detection.
  - ACC_WIDTH=36 is exact for up to 256 full-scale beats.
- prod_last is ignored when prod_valid=0.
- Beats presented in RQ/OUT are not consumed; the upstream stage holds them.
- ap_rst mid-vector or while in OUT:
  - Partial sum and pending result are discarded.
  - Reset values are applied at the next edge.
  - No result is emitted.

Optional Feature:
MYPROJECT_ACC_RELU_EN
- Defined: ReLU is applied after saturation; a negative result becomes 0.
- res_ovf still reports saturation of the pre-ReLU value.
- Latency is unchanged.
- Undefined: signed result passed unmodified.

Test Plan:
1. Single beat, bias=0, prod=12288, last=1 -> res_dout=3, res_ovf=0, res_valid exactly 2 cycles after accept. Rounding: prod=2048 -> 1; prod=-2049 -> -1.
2. Three beats 4096, 8192, -2048 with bias=1 and last on beat 3 -> acc=14336, res_dout=4 (rounded), res_ovf=0; prod_ready=0 during RQ/OUT.
3. Saturation: two beats of 2^26 -> res_dout=0x7FFF, res_ovf=1. Three beats of -2^26 -> res_dout=0x8000, res_ovf=1. Two beats of -2^26 -> exactly -32768, res_ovf=0.
4. Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_dout/res_ovf stable, prod_ready=0, upstream beat not consumed. The next vector's first beat is accepted one cycle after the handshake, using the new bias.
5. Reset mid-vector: 2 beats accepted, assert ap_rst one cycle -> all outputs at reset values. The next single-beat vector (bias=0, prod=4096) yields 1, with no contamination from the discarded partial sum.
6. With MYPROJECT_ACC_RELU_EN: single beat -8192, bias=0 -> res_dout=0, res_ovf=0. Three beats of -2^26 -> res_dout=0, res_ovf=1. Without the macro, the first case gives res_dout=-2.

Source files
------------

// File: rtl/myproject_acc_requant_28s_16s.sv
// Dot-product accumulator with bias, round-half-up requantisation and saturation to 16 bits.
// Optional ReLU on the saturated result is enabled by defining MYPROJECT_ACC_RELU_EN.
module myproject_acc_requant_28s_16s #(
  parameter int PROD_WIDTH = 28,
  parameter int ACC_WIDTH  = 36,
  parameter int BIAS_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 12
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_valid,
  input  logic                  prod_last,
  output logic                  prod_ready,
  input  logic [BIAS_WIDTH-1:0] bias_din,
  output logic [OUT_WIDTH-1:0]  res_dout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_ovf,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RQ   = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [OUT_WIDTH-1:0] OUT_MAX_W = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN_W = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] LIM_HI   = ACC_WIDTH'($signed(OUT_MAX_W));
  localparam logic signed [ACC_WIDTH-1:0] LIM_LO   = ACC_WIDTH'($signed(OUT_MIN_W));
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]          res_dout_q, res_dout_d;
  logic                          res_valid_q, res_valid_d;
  logic                          res_ovf_q, res_ovf_d;

  logic                          accept;
  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   bias_ext;
  logic signed [ACC_WIDTH-1:0]   rnd_sum;
  logic signed [ACC_WIDTH-1:0]   shifted;
  logic [OUT_WIDTH-1:0]          sat_val;
  logic                          sat_ovf;
  logic [OUT_WIDTH-1:0]          final_val;

  assign prod_ready = (state_q == IDLE) || (state_q == ACC);
  assign accept     = prod_valid & prod_ready;
  assign prod_ext   = ACC_WIDTH'($signed(prod_din));
  assign bias_ext   = ACC_WIDTH'($signed(bias_din));

  // Round-half-up then arithmetic shift; clamp to the signed output range.
  always_comb begin
    rnd_sum = acc_q + RND_HALF;
    shifted = rnd_sum >>> FRAC_SHIFT;
    sat_val = shifted[OUT_WIDTH-1:0];
    sat_ovf = 1'b0;
    if (shifted > LIM_HI) begin
      sat_val = OUT_MAX_W;
      sat_ovf = 1'b1;
    end else if (shifted < LIM_LO) begin
      sat_val = OUT_MIN_W;
      sat_ovf = 1'b1;
    end
`ifdef MYPROJECT_ACC_RELU_EN
    final_val = sat_val[OUT_WIDTH-1] ? '0 : sat_val;
`else
    final_val = sat_val;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    res_dout_d  = res_dout_q;
    res_valid_d = res_valid_q;
    res_ovf_d   = res_ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = (bias_ext <<< FRAC_SHIFT) + prod_ext;
          state_d = prod_last ? RQ : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = acc_q + prod_ext;
          state_d = prod_last ? RQ : ACC;
        end
      end
      RQ: begin
        res_dout_d  = final_val;
        res_ovf_d   = sat_ovf;
        res_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      res_dout_q  <= '0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_dout_q  <= res_dout_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign res_dout  = res_dout_q;
  assign res_valid = res_valid_q;
  assign res_ovf   = res_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_myproject_acc_requant_28s_16s.sv
// Self-checking bench for myproject_acc_requant_28s_16s: directed plan cases plus
// randomized vectors against a plain-arithmetic reference model.
module tb_myproject_acc_requant_28s_16s;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic [27:0]        prod_din;
  logic               prod_valid;
  logic               prod_last;
  logic               prod_ready;
  logic [15:0]        bias_din;
  logic [15:0]        res_dout;
  logic               res_valid;
  logic               res_ready;
  logic               res_ovf;
  logic               busy;

  int testsRun    = 0;
  int testsFailed = 0;

  logic signed [27:0] beatBuf[$];
  longint             lastDout;
  longint             lastOvf;
  int                 firstWait;

  myproject_acc_requant_28s_16s dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .prod_din   (prod_din),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .bias_din   (bias_din),
    .res_dout   (res_dout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_ovf    (res_ovf),
    .busy       (busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference: bias scaled up, products summed, then round-half-up, floor shift, clamp.
  function automatic void modelResult(input int bias, output longint dout, output longint ovf);
    longint sum;
    longint r;
    sum = longint'(bias) * 4096;
    foreach (beatBuf[i]) sum += longint'(beatBuf[i]);
    r   = (sum + 2048) >>> 12;
    ovf = 0;
    if (r > 32767) begin
      r = 32767; ovf = 1;
    end else if (r < -32768) begin
      r = -32768; ovf = 1;
    end
`ifdef MYPROJECT_ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    dout = r;
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic sendBeats(input int bias, input bit gaps);
    int waited;
    for (int i = 0; i < beatBuf.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        prod_valid = 1'b0;
        tick();
      end
      prod_valid = 1'b1;
      prod_din   = beatBuf[i];
      prod_last  = (i == beatBuf.size() - 1);
      if (i == 0) bias_din = 16'(bias);
      waited = 0;
      while (!prod_ready && waited < 20) begin
        tick();
        waited++;
      end
      if (waited >= 20) checkOutput("accept_timeout", 0, 1);
      if (i == 0) firstWait = waited;
      tick();
      bias_din = 16'($urandom);
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int bias, input int stall);
    longint expDout;
    longint expOvf;
    modelResult(bias, expDout, expOvf);
    checkOutput({tag, "_rq_valid"}, longint'(res_valid), 0);
    checkOutput({tag, "_rq_ready"}, longint'(prod_ready), 0);
    tick();
    checkOutput({tag, "_latency"}, longint'(res_valid), 1);
    lastDout = longint'($signed(res_dout));
    lastOvf  = longint'(res_ovf);
    checkOutput({tag, "_dout"}, lastDout, expDout);
    checkOutput({tag, "_ovf"}, lastOvf, expOvf);
    for (int s = 0; s < stall; s++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, longint'(res_valid), 1);
      checkOutput({tag, "_hold_dout"}, longint'($signed(res_dout)), expDout);
      checkOutput({tag, "_hold_ovf"}, longint'(res_ovf), expOvf);
      checkOutput({tag, "_hold_ready"}, longint'(prod_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, longint'(res_valid), 0);
    checkOutput({tag, "_done_busy"}, longint'(busy), 0);
  endtask

  task automatic applyStimulus(input string tag, input int bias, input int stall, input bit gaps);
    sendBeats(bias, gaps);
    waitResult(tag, bias, stall);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ap_rst     = 1'b1;
    prod_din   = '0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    bias_din   = '0;
    res_ready  = 1'b0;
    tick();
    tick();
    ap_rst = 1'b0;

    checkOutput("rst_dout", longint'(res_dout), 0);
    checkOutput("rst_valid", longint'(res_valid), 0);
    checkOutput("rst_ovf", longint'(res_ovf), 0);
    checkOutput("rst_busy", longint'(busy), 0);
    checkOutput("rst_ready", longint'(prod_ready), 1);

    // Single beats and rounding
    beatBuf = {28'sd12288};
    applyStimulus("single", 0, 0, 1'b0);
    checkOutput("single_const", lastDout, 3);
    beatBuf = {28'sd2048};
    applyStimulus("rnd_up", 0, 0, 1'b0);
    checkOutput("rnd_up_const", lastDout, 1);
    beatBuf = {-28'sd2049};
    applyStimulus("rnd_neg", 0, 0, 1'b0);
`ifndef MYPROJECT_ACC_RELU_EN
    checkOutput("rnd_neg_const", lastDout, -1);
`endif

    // Three beats with bias
    beatBuf = {28'sd4096, 28'sd8192, -28'sd2048};
    applyStimulus("three", 1, 0, 1'b0);
    checkOutput("three_const", lastDout, 4);

    // Saturation
    beatBuf = {28'sd67108864, 28'sd67108864};
    applyStimulus("sat_pos", 0, 0, 1'b0);
    checkOutput("sat_pos_const", lastDout, 32767);
    checkOutput("sat_pos_ovf_const", lastOvf, 1);
    beatBuf = {-28'sd67108864, -28'sd67108864, -28'sd67108864};
    applyStimulus("sat_neg", 0, 0, 1'b0);
    checkOutput("sat_neg_ovf_const", lastOvf, 1);
    beatBuf = {-28'sd67108864, -28'sd67108864};
    applyStimulus("min_exact", 0, 0, 1'b0);
    checkOutput("min_exact_ovf_const", lastOvf, 0);

    // Backpressure with the next vector's first beat waiting upstream
    beatBuf = {28'sd8192};
    sendBeats(2, 1'b0);
    prod_valid = 1'b1;
    prod_din   = 28'sd4096;
    prod_last  = 1'b1;
    bias_din   = 16'sd3;
    waitResult("bp", 2, 5);
    beatBuf = {28'sd4096};
    sendBeats(3, 1'b0);
    checkOutput("bp_next_wait", longint'(firstWait), 0);
    waitResult("bp_next", 3, 0);
    checkOutput("bp_next_const", lastDout, 4);

    // Reset mid-vector
    prod_valid = 1'b1;
    prod_last  = 1'b0;
    bias_din   = 16'sd7;
    prod_din   = 28'sd100000;
    tick();
    prod_din = 28'sd200000;
    tick();
    prod_valid = 1'b0;
    checkOutput("mid_busy", longint'(busy), 1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    checkOutput("mid_rst_busy", longint'(busy), 0);
    checkOutput("mid_rst_valid", longint'(res_valid), 0);
    checkOutput("mid_rst_dout", longint'(res_dout), 0);
    checkOutput("mid_rst_ovf", longint'(res_ovf), 0);
    beatBuf = {28'sd4096};
    applyStimulus("post_rst", 0, 0, 1'b0);
    checkOutput("post_rst_const", lastDout, 1);

    // Negative result, ReLU-dependent
    beatBuf = {-28'sd8192};
    applyStimulus("neg", 0, 0, 1'b0);
`ifdef MYPROJECT_ACC_RELU_EN
    checkOutput("neg_const", lastDout, 0);
`else
    checkOutput("neg_const", lastDout, -2);
`endif

    // Randomized vectors
    for (int v = 0; v < 25; v++) begin
      int len;
      int bias;
      len = $urandom_range(1, 8);
      beatBuf.delete();
      for (int b = 0; b < len; b++) beatBuf.push_back(28'($urandom));
      bias = int'($signed(16'($urandom)));
      applyStimulus("rand", bias, $urandom_range(0, 3), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
